line_rasterizer: RTL and testbench
==================================

LINE_RASTERIZER -- requirements
Module: line_rasterizer

Interface
REQ-001 SHALL have parameter X_W, default 10, the x coordinate width (640-pixel screen).
REQ-002 SHALL have parameter Y_W, default 9, the y coordinate width (480-line screen).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, the reset; asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, the request to draw; sampled only in IDLE.
REQ-006 SHALL have ports x0, x1, input, X_W, the endpoint x coordinates; captured when start is accepted.
REQ-007 SHALL have ports y0, y1, input, Y_W, the endpoint y coordinates; captured when start is accepted.
REQ-008 SHALL have port color_in, input, 1, the line colour (1 white, 0 black/erase); captured when start is accepted.
REQ-009 SHALL have port x, output, X_W, the current pixel x, driven to VGA_framebuffer.
REQ-010 SHALL have port y, output, Y_W, the current pixel y, driven to VGA_framebuffer.
REQ-011 SHALL have port pixel_color, output, 1, the captured colour for the current pixel.
REQ-012 SHALL have port pixel_write, output, 1, high for exactly the cycles in which x/y hold a valid pixel.
REQ-013 SHALL have port busy, output, 1, high in SETUP, DRAW and DONE.
REQ-014 SHALL have port done, output, 1, a one-cycle pulse after the last pixel.

Function
REQ-015 SHALL implement the FSM IDLE -> SETUP -> DRAW -> DONE -> IDLE, with all outputs registered.
REQ-016 SHALL move from IDLE to SETUP on the edge where start=1 and SHALL ignore start in all other states (no queuing).
REQ-017 SHALL in SETUP, in one cycle: set steep = |y1-y0| > |x1-x0|; swap x and y when steep; swap endpoints when major start > major end; set dx = major span, dy = |minor span|, err = -floor(dx/2), ystep = +1 or -1.
REQ-018 SHALL hold the internal coordinates at max(X_W,Y_W) bits and err as a signed max(X_W,Y_W)+2 bit value, with no overflow for any legal input.
REQ-019 SHALL in DRAW emit one pixel per cycle with pixel_write=1; output (x,y) SHALL be (minor,major) when steep and (major,minor) otherwise.
REQ-020 SHALL after each pixel do err += dy, and when the new err >= 0 also do minor += ystep and err -= dx; the major coordinate SHALL increment by 1.
REQ-021 SHALL emit exactly max(|x1-x0|,|y1-y0|)+1 pixels, in increasing major-axis order, then enter DONE.
REQ-022 SHALL raise the first pixel_write two edges after start is accepted; the last pixel is followed by done=1 on the next cycle, then IDLE.
REQ-023 SHALL treat a degenerate line (x0=x1, y0=y1) as exactly one pixel write.
REQ-024 SHALL drive pixel_write=0 in IDLE, SETUP and DONE; x/y SHALL hold their last value there.

Reset
REQ-025 SHALL on reset_n=0, asynchronously: state=IDLE, x=0, y=0, pixel_color=0, pixel_write=0, busy=0, done=0, err=0.
REQ-026 SHALL on reset during DRAW abort immediately, with no further writes and no done pulse; a new start SHALL be accepted on the first edge after reset_n rises.

Configuration
REQ-027 SHALL, when LINE_RASTERIZER_CLIP_EN is defined, force pixel_write=0 for any pixel with x>=640 or y>=480, while still stepping and counting that pixel so that timing and done are unchanged.
REQ-028 SHALL, when LINE_RASTERIZER_CLIP_EN is undefined, write every pixel regardless of range, with no clip logic present.

Verification
REQ-029 SHALL cover: start with (100,100)->(200,100), color 1 -> 101 writes, x=100..200, y=100, first write 2 cycles after start, done 1 cycle after x=200.
REQ-030 SHALL cover: (3,3)->(0,0) -> 4 writes (0,0),(1,1),(2,2),(3,3), then busy falls after done.
REQ-031 SHALL cover: steep reversed line (5,9)->(3,2) -> 8 writes (3,2),(3,3),(4,4),(4,5),(4,6),(5,7),(5,8),(5,9).
REQ-032 SHALL cover: (7,7)->(7,7) -> one write at (7,7); start re-asserted while busy -> ignored, no second line.
REQ-033 SHALL cover: reset_n low for 2 cycles during pixel 50 of a 101-pixel line -> pixel_write=0 immediately, no done, next start draws normally.
REQ-034 SHALL cover, with LINE_RASTERIZER_CLIP_EN defined: (630,10)->(650,10) -> writes only for x=630..639, done still at pixel 21 timing.

Source files
------------

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer feeding a framebuffer one pixel per clock; LINE_RASTERIZER_CLIP_EN masks writes outside 640x480.
// Latency: first pixel_write two edges after start is accepted, done one cycle after the last pixel.
// Backpressure: none; start is ignored unless the engine is idle.
module line_rasterizer #(
    parameter int X_W = 10,
    parameter int Y_W = 9
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [X_W-1:0] x0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y0,
    input  logic [Y_W-1:0] y1,
    input  logic           color_in,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           pixel_color,
    output logic           pixel_write,
    output logic           busy,
    output logic           done
);
    localparam int C_W = (X_W > Y_W) ? X_W : Y_W;
    localparam int E_W = C_W + 2;

    typedef logic [C_W-1:0]        coord_t;
    typedef logic signed [E_W-1:0] err_t;
    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

`ifdef LINE_RASTERIZER_CLIP_EN
    localparam logic [C_W:0] X_LIM = (C_W+1)'(640);
    localparam logic [C_W:0] Y_LIM = (C_W+1)'(480);
`endif

    state_t         state_q, state_d;
    coord_t         ex0_q, ex1_q, ey0_q, ey1_q;
    coord_t         ex0_d, ex1_d, ey0_d, ey1_d;
    logic           color_q, color_d;
    logic           steep_q, steep_d;
    logic           yneg_q, yneg_d;
    coord_t         major_q, major_d;
    coord_t         major_end_q, major_end_d;
    coord_t         minor_q, minor_d;
    coord_t         dx_q, dx_d;
    coord_t         dy_q, dy_d;
    err_t           err_q, err_d;
    logic [X_W-1:0] x_d;
    logic [Y_W-1:0] y_d;
    logic           pixel_color_d, pixel_write_d, busy_d, done_d;

    coord_t adx, ady, a0, a1, b0, b1, sa0, sa1, sb0, sb1, dx_c, dy_c;
    logic   steep_c, swap_c;

    // Setup arithmetic on the captured endpoints: pick major axis, then order along it.
    always_comb begin
        adx     = (ex0_q >= ex1_q) ? ex0_q - ex1_q : ex1_q - ex0_q;
        ady     = (ey0_q >= ey1_q) ? ey0_q - ey1_q : ey1_q - ey0_q;
        steep_c = ady > adx;
        a0      = steep_c ? ey0_q : ex0_q;
        a1      = steep_c ? ey1_q : ex1_q;
        b0      = steep_c ? ex0_q : ey0_q;
        b1      = steep_c ? ex1_q : ey1_q;
        swap_c  = a0 > a1;
        sa0     = swap_c ? a1 : a0;
        sa1     = swap_c ? a0 : a1;
        sb0     = swap_c ? b1 : b0;
        sb1     = swap_c ? b0 : b1;
        dx_c    = sa1 - sa0;
        dy_c    = (sb1 >= sb0) ? sb1 - sb0 : sb0 - sb1;
    end

    coord_t px, py;
    err_t   err_add;

    always_comb begin
        px      = steep_q ? minor_q : major_q;
        py      = steep_q ? major_q : minor_q;
        err_add = err_q + err_t'(dy_q);

        state_d       = state_q;
        ex0_d         = ex0_q;
        ex1_d         = ex1_q;
        ey0_d         = ey0_q;
        ey1_d         = ey1_q;
        color_d       = color_q;
        steep_d       = steep_q;
        yneg_d        = yneg_q;
        major_d       = major_q;
        major_end_d   = major_end_q;
        minor_d       = minor_q;
        dx_d          = dx_q;
        dy_d          = dy_q;
        err_d         = err_q;
        x_d           = x;
        y_d           = y;
        pixel_color_d = pixel_color;
        pixel_write_d = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    ex0_d   = coord_t'(x0);
                    ex1_d   = coord_t'(x1);
                    ey0_d   = coord_t'(y0);
                    ey1_d   = coord_t'(y1);
                    color_d = color_in;
                    busy_d  = 1'b1;
                end
            end
            SETUP: begin
                state_d     = DRAW;
                steep_d     = steep_c;
                yneg_d      = sb1 < sb0;
                major_d     = sa0;
                major_end_d = sa1;
                minor_d     = sb0;
                dx_d        = dx_c;
                dy_d        = dy_c;
                err_d       = -err_t'(dx_c >> 1);
                busy_d      = 1'b1;
            end
            DRAW: begin
                busy_d        = 1'b1;
                x_d           = X_W'(px);
                y_d           = Y_W'(py);
                pixel_color_d = color_q;
`ifdef LINE_RASTERIZER_CLIP_EN
                // Off-screen pixels still consume their cycle so done timing is unchanged.
                pixel_write_d = ({1'b0, px} < X_LIM) && ({1'b0, py} < Y_LIM);
`else
                pixel_write_d = 1'b1;
`endif
                major_d = major_q + coord_t'(1);
                if (!err_add[E_W-1]) begin
                    minor_d = yneg_q ? minor_q - coord_t'(1) : minor_q + coord_t'(1);
                    err_d   = err_add - err_t'(dx_q);
                end else begin
                    err_d   = err_add;
                end
                if (major_q == major_end_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ex0_q       <= '0;
            ex1_q       <= '0;
            ey0_q       <= '0;
            ey1_q       <= '0;
            color_q     <= 1'b0;
            steep_q     <= 1'b0;
            yneg_q      <= 1'b0;
            major_q     <= '0;
            major_end_q <= '0;
            minor_q     <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            err_q       <= '0;
            x           <= '0;
            y           <= '0;
            pixel_color <= 1'b0;
            pixel_write <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ex0_q       <= ex0_d;
            ex1_q       <= ex1_d;
            ey0_q       <= ey0_d;
            ey1_q       <= ey1_d;
            color_q     <= color_d;
            steep_q     <= steep_d;
            yneg_q      <= yneg_d;
            major_q     <= major_d;
            major_end_q <= major_end_d;
            minor_q     <= minor_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            err_q       <= err_d;
            x           <= x_d;
            y           <= y_d;
            pixel_color <= pixel_color_d;
            pixel_write <= pixel_write_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end
endmodule

// File: tb/tb_line_rasterizer.sv
// Directed and random lines checked against an integer model of the line-drawing rules.
// Pixel stream, per-pixel cycle, done timing, busy, reset abort and start-while-busy are checked.
// Backpressure: not applicable.
module tb_line_rasterizer;
    localparam int X_W = 10;
    localparam int Y_W = 9;
    localparam int C_MASK = 1023;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic           color_in = 1'b0;
    logic [X_W-1:0] x0 = '0, x1 = '0, x;
    logic [Y_W-1:0] y0 = '0, y1 = '0, y;
    logic           pixel_color, pixel_write, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {int px; int py; int k;} pix_t;
    pix_t exp_q[$];
    pix_t got_q[$];
    int   got_col[$];
    int   got_cyc[$];
    int   exp_n;

    int ex31[8] = '{3, 3, 4, 4, 4, 5, 5, 5};
    int ey31[8] = '{2, 3, 4, 5, 6, 7, 8, 9};

    line_rasterizer #(.X_W(X_W), .Y_W(Y_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color_in(color_in),
        .x(x), .y(y), .pixel_color(pixel_color), .pixel_write(pixel_write),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Walks the line with plain integers, major coordinate ascending.
    task automatic model(input int ax0, input int ay0, input int ax1, input int ay1);
        int a0, a1, b0, b1, t, dx, dy, err, minor, ystep;
        bit steep;
        pix_t p;
        steep = iabs(ay1 - ay0) > iabs(ax1 - ax0);
        if (steep) begin a0 = ay0; a1 = ay1; b0 = ax0; b1 = ax1; end
        else       begin a0 = ax0; a1 = ax1; b0 = ay0; b1 = ay1; end
        if (a0 > a1) begin
            t = a0; a0 = a1; a1 = t;
            t = b0; b0 = b1; b1 = t;
        end
        dx = a1 - a0;
        dy = iabs(b1 - b0);
        ystep = (b1 >= b0) ? 1 : -1;
        err = -(dx / 2);
        minor = b0;
        exp_q.delete();
        exp_n = dx + 1;
        for (int k = 0; k <= dx; k++) begin
            p.px = steep ? minor : a0 + k;
            p.py = steep ? a0 + k : minor;
            p.k  = k;
`ifdef LINE_RASTERIZER_CLIP_EN
            if (p.px < 640 && p.py < 480) exp_q.push_back(p);
`else
            exp_q.push_back(p);
`endif
            err += dy;
            if (err >= 0) begin
                minor = (minor + ystep) & C_MASK;
                err -= dx;
            end
        end
    endtask

    task automatic draw(input int ax0, input int ay0, input int ax1, input int ay1,
                        input int col, input bit poke, input string tag);
        int acc, done_cyc, n, extra;
        model(ax0, ay0, ax1, ay1);
        x0 = X_W'(ax0); y0 = Y_W'(ay0); x1 = X_W'(ax1); y1 = Y_W'(ay1);
        color_in = col[0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        acc = cyc;
        chk({tag, " busy_after_start"}, busy, 1);
        if (poke) begin
            start = 1'b1; x0 = '0; y0 = '0; x1 = 10'd50; y1 = 9'd0;
        end
        got_q.delete(); got_col.delete(); got_cyc.delete();
        done_cyc = -1;
        for (int t = 0; t < 3000 && done_cyc < 0; t++) begin
            @(negedge clk);
            if (pixel_write) begin
                got_q.push_back('{px: int'(x), py: int'(y), k: 0});
                got_col.push_back(int'(pixel_color));
                got_cyc.push_back(cyc);
            end
            if (done) done_cyc = cyc;
        end
        start = 1'b0;
        chk({tag, " done_seen"}, done_cyc >= 0, 1);
        chk({tag, " write_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s x[%0d]", tag, i), got_q[i].px, exp_q[i].px & C_MASK);
            chk($sformatf("%s y[%0d]", tag, i), got_q[i].py, exp_q[i].py & 511);
            chk($sformatf("%s col[%0d]", tag, i), got_col[i], col & 1);
            chk($sformatf("%s cyc[%0d]", tag, i), got_cyc[i], acc + 2 + exp_q[i].k);
        end
        chk({tag, " done_cycle"}, done_cyc, acc + 2 + exp_n);
        @(negedge clk);
        chk({tag, " busy_after_done"}, busy, 0);
        chk({tag, " done_one_cycle"}, done, 0);
        if (poke) begin
            extra = 0;
            for (int t = 0; t < 60; t++) begin
                @(negedge clk);
                if (pixel_write || busy || done) extra++;
            end
            chk({tag, " start_while_busy_ignored"}, extra, 0);
        end
    endtask

    initial begin
        int cnt, rx0, ry0, rx1, ry1;
        #2;
        chk("rst x", x, 0);
        chk("rst y", y, 0);
        chk("rst pixel_color", pixel_color, 0);
        chk("rst pixel_write", pixel_write, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle busy", busy, 0);
        chk("idle pixel_write", pixel_write, 0);

        draw(100, 100, 200, 100, 1, 1'b0, "horiz");
        for (int i = 0; i < got_q.size(); i++) begin
            chk($sformatf("horiz const x[%0d]", i), got_q[i].px, 100 + i);
            chk($sformatf("horiz const y[%0d]", i), got_q[i].py, 100);
        end

        draw(3, 3, 0, 0, 1, 1'b0, "diag");
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            chk($sformatf("diag const x[%0d]", i), got_q[i].px, i);
            chk($sformatf("diag const y[%0d]", i), got_q[i].py, i);
        end

        draw(5, 9, 3, 2, 0, 1'b0, "steep");
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            chk($sformatf("steep const x[%0d]", i), got_q[i].px, ex31[i]);
            chk($sformatf("steep const y[%0d]", i), got_q[i].py, ey31[i]);
        end

        draw(7, 7, 7, 7, 1, 1'b1, "dot");

        model(100, 100, 200, 100);
        x0 = 10'd100; y0 = 9'd100; x1 = 10'd200; y1 = 9'd100; color_in = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        for (int t = 0; t < 300 && cnt < 50; t++) begin
            @(negedge clk);
            if (pixel_write) cnt++;
        end
        chk("abort reached pixel 50", cnt, 50);
        reset_n = 1'b0;
        #1;
        chk("abort pixel_write", pixel_write, 0);
        chk("abort busy", busy, 0);
        chk("abort x", x, 0);
        chk("abort y", y, 0);
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            chk("abort hold pixel_write", pixel_write, 0);
            chk("abort hold done", done, 0);
        end
        reset_n = 1'b1;
        draw(10, 20, 40, 35, 1, 1'b0, "after_reset");

        draw(630, 10, 650, 10, 1, 1'b0, "clip");

        for (int r = 0; r < 14; r++) begin
            rx0 = $urandom_range(0, 1023);
            ry0 = $urandom_range(0, 511);
            if (r[0]) begin
                rx1 = $urandom_range(0, 1023);
                ry1 = $urandom_range(0, 511);
            end else begin
                rx1 = rx0 + $urandom_range(0, 16) - 8;
                ry1 = ry0 + $urandom_range(0, 16) - 8;
                if (rx1 < 0) rx1 = 0;
                if (rx1 > 1023) rx1 = 1023;
                if (ry1 < 0) ry1 = 0;
                if (ry1 > 511) ry1 = 511;
            end
            draw(rx0, ry0, rx1, ry1, int'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
